// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO block family.
// No logic; imported by the FIFO readers and their helpers.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_PACK         = 4;
    localparam int DEFAULT_IDLE_TIMEOUT = 16;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle-cycle counter; expire pulses combinationally on the cycle the count would reach IDLE_TIMEOUT.
// No backpressure; clr wins over en. IDLE_TIMEOUT=0 collapses to a constant-0 expire.
module fifo_idle_timer #(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    generate
        if (IDLE_TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, en, clr};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int TW = $clog2(IDLE_TIMEOUT + 1);
            localparam logic [TW-1:0] LAST = TW'(IDLE_TIMEOUT - 1);

            logic [TW-1:0] idle_cnt;

            assign expire = en && !clr && (idle_cnt == LAST);

            always_ff @(posedge clk) begin
                if (!rst_n || clr) begin
                    idle_cnt <= '0;
                end else if (en) begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fifo_pack_reader.sv
// Packs PACK show-ahead FIFO words into one wide beat; beat is registered one cycle after its last word pops.
// Holds the beat stable under out_ready=0 and stops popping until it is accepted; partial beats on flush/idle.
module fifo_pack_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int PACK         = DEFAULT_PACK,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_pop,
    input  logic                       flush_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [$clog2(PACK+1)-1:0]  out_count,
    output logic                       out_partial,
    output logic                       busy
);

    localparam int CW = clog2p1(PACK);
    localparam int LW = $clog2(PACK);
    localparam logic [CW-1:0] FULL = CW'(PACK);

    pack_state_t               state;
    logic [CW-1:0]             count;
    logic [CW-1:0]             words;
    logic [DATA_WIDTH-1:0]     lanes     [PACK];
    logic [DATA_WIDTH-1:0]     lanes_nxt [PACK];
    logic [DATA_WIDTH*PACK-1:0] pack_flat;
    logic                      fill_pop;
    logic                      emit;
    logic                      idle_en;
    logic                      idle_clr;
    logic                      idle_expire;

    assign in_pop   = in_valid && (state == FILL || (state == HOLD && out_ready));
    assign fill_pop = in_pop && (state == FILL);
    assign busy     = (count != '0) || out_valid;
    assign idle_en  = (state == FILL) && (count != '0) && !in_pop;
    assign idle_clr = in_pop || (state != FILL);

    fifo_idle_timer #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (idle_en),
        .clr    (idle_clr),
        .expire (idle_expire)
    );

    // The word popped this cycle is folded in so a flush or full pack includes it.
    always_comb begin
        lanes_nxt = lanes;
        pack_flat = '0;
        if (fill_pop) begin
            lanes_nxt[count[LW-1:0]] = in_data;
        end
        words = count + CW'(fill_pop);
        emit  = (state == FILL) &&
                ((words == FULL) || ((flush_req || idle_expire) && (words != '0)));
        for (int i = 0; i < PACK; i++) begin
            pack_flat[i*DATA_WIDTH +: DATA_WIDTH] = lanes_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            count       <= '0;
            lanes       <= '{default: '0};
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_count   <= '0;
            out_partial <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (emit) begin
                        state       <= HOLD;
                        out_valid   <= 1'b1;
                        out_data    <= pack_flat;
                        out_count   <= words;
                        out_partial <= (words < FULL);
                        count       <= '0;
                        // Cleared lanes make unfilled lanes of the next partial beat read as zero.
                        lanes       <= '{default: '0};
                    end else begin
                        count <= words;
                        lanes <= lanes_nxt;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        if (in_pop) begin
                            lanes[0] <= in_data;
                            count    <= CW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Directed bench for fifo_pack_reader (DATA_WIDTH=8, PACK=4, IDLE_TIMEOUT=16) plus a no-timeout twin.
module tb_fifo_pack_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush_req;
    logic        out_ready;

    logic        in_pop, out_valid, out_partial, busy;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    logic        nt_pop, nt_valid, nt_partial, nt_busy;
    logic [31:0] nt_data;
    logic [2:0]  nt_count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_pack_reader #(.DATA_WIDTH(8), .PACK(4), .IDLE_TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_pop(in_pop),
        .flush_req(flush_req), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_partial(out_partial), .busy(busy)
    );

    fifo_pack_reader #(.DATA_WIDTH(8), .PACK(4), .IDLE_TIMEOUT(0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_pop(nt_pop),
        .flush_req(flush_req), .out_valid(nt_valid), .out_ready(out_ready), .out_data(nt_data),
        .out_count(nt_count), .out_partial(nt_partial), .busy(nt_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] w, input logic exp_pop, input string tag);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        chk(tag, in_pop, exp_pop);
        tick();
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [2:0] c, input logic p);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_partial"}, out_partial, p);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush_req = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_count", out_count, 3'd0);
        chk("rst_partial", out_partial, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pop", in_pop, 1'b0);
        rst_n = 1'b1;
        tick();

        // Full pack with ready downstream
        out_ready = 1'b1;
        push(8'h11, 1'b1, "full_pop0");
        push(8'h22, 1'b1, "full_pop1");
        push(8'h33, 1'b1, "full_pop2");
        push(8'h44, 1'b1, "full_pop3");
        in_valid = 1'b0;
        chk_beat("full", 32'h44332211, 3'd4, 1'b0);
        tick();
        chk("full_accepted", out_valid, 1'b0);
        chk("full_idle_busy", busy, 1'b0);

        // Back-to-back with 3 cycles of backpressure on the first beat
        out_ready = 1'b0;
        push(8'h11, 1'b1, "bp_pop0");
        push(8'h22, 1'b1, "bp_pop1");
        push(8'h33, 1'b1, "bp_pop2");
        push(8'h44, 1'b1, "bp_pop3");
        chk_beat("bp_first", 32'h44332211, 3'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_hold_pop", in_pop, 1'b0);
            tick();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, 32'h44332211);
        end
        out_ready = 1'b1;
        push(8'h55, 1'b1, "bp_accept_pop");
        chk("bp_accepted", out_valid, 1'b0);
        chk("bp_busy_count1", busy, 1'b1);
        push(8'h66, 1'b1, "bp_pop5");
        push(8'h77, 1'b1, "bp_pop6");
        push(8'h88, 1'b1, "bp_pop7");
        in_valid = 1'b0;
        chk_beat("bp_second", 32'h88776655, 3'd4, 1'b0);
        tick();
        chk("bp_second_accepted", out_valid, 1'b0);

        // Explicit flush of a two-word partial pack
        out_ready = 1'b0;
        push(8'hA1, 1'b1, "fl_pop0");
        push(8'hA2, 1'b1, "fl_pop1");
        in_valid  = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk_beat("flush", 32'h0000A2A1, 3'd2, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("flush_accepted", out_valid, 1'b0);
        flush_req = 1'b1;
        tick();
        tick();
        flush_req = 1'b0;
        chk("flush_empty_valid", out_valid, 1'b0);
        chk("flush_empty_busy", busy, 1'b0);

        // Accept-and-pop in the same cycle seeds lane 0 of the next pack
        out_ready = 1'b0;
        push(8'hE1, 1'b1, "ap_pop0");
        push(8'hE2, 1'b1, "ap_pop1");
        push(8'hE3, 1'b1, "ap_pop2");
        push(8'hE4, 1'b1, "ap_pop3");
        chk_beat("ap_first", 32'hE4E3E2E1, 3'd4, 1'b0);
        out_ready = 1'b1;
        push(8'hEE, 1'b1, "ap_accept_pop");
        chk("ap_accepted", out_valid, 1'b0);
        chk("ap_busy", busy, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk_beat("ap_lane0", 32'h000000EE, 3'd1, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("ap_drained", busy, 1'b0);

        // Idle timeout after a single word
        out_ready = 1'b0;
        push(8'h5A, 1'b1, "idle_pop");
        in_valid = 1'b0;
        repeat (15) tick();
        chk("idle_15_valid", out_valid, 1'b0);
        chk("idle_15_busy", busy, 1'b1);
        tick();
        chk_beat("idle_16", 32'h0000005A, 3'd1, 1'b1);
        repeat (30) tick();
        chk("idle_off_valid", nt_valid, 1'b0);
        chk("idle_off_busy", nt_busy, 1'b1);
        chk("idle_held_data", out_data, 32'h0000005A);
        out_ready = 1'b1;
        tick();
        chk("idle_accepted", out_valid, 1'b0);

        // Reset while a three-word beat is held
        out_ready = 1'b0;
        push(8'h31, 1'b1, "rs_pop0");
        push(8'h32, 1'b1, "rs_pop1");
        push(8'h33, 1'b1, "rs_pop2");
        in_valid  = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk_beat("rs_hold", 32'h00333231, 3'd3, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rs_valid", out_valid, 1'b0);
        chk("rs_data", out_data, 32'h0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_pop", in_pop, 1'b0);
        chk("rs_nt_busy", nt_busy, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(8'h01, 1'b1, "rs_new0");
        push(8'h02, 1'b1, "rs_new1");
        push(8'h03, 1'b1, "rs_new2");
        push(8'h04, 1'b1, "rs_new3");
        in_valid = 1'b0;
        chk_beat("rs_clean", 32'h04030201, 3'd4, 1'b0);
        tick();
        chk("rs_clean_accepted", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
- Drains the read side of the team's synchronous FIFO (show-ahead: `rd_data` valid whenever `rd_valid`; pop = `rd_en && rd_valid`).
- Packs PACK consecutive DATA_WIDTH words into one wide beat and presents it downstream on a valid/ready handshake.
- Partial beats are emitted on explicit flush or after an idle timeout.
- Sits between a byte/word FIFO and a wide datapath consumer.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word.
- PACK, 4, words per output beat (≥2).
- IDLE_TIMEOUT, 16, consecutive idle cycles before a partial beat is auto-emitted; 0 disables.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  FIFO `rd_valid`.
- in_data  in  DATA_WIDTH  FIFO `rd_data`.
- in_pop  out  1  FIFO `rd_en`; combinational.
- flush_req  in  1  level; emit current partial pack.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_WIDTH*PACK  packed beat; word 0 in LSBs.
- out_count  out  $clog2(PACK+1)  number of valid words in beat (1..PACK).
- out_partial  out  1  out_count < PACK.
- busy  out  1  count>0 or out_valid.

Behaviour:
- Reset: state FILL, count=0, out_valid=0, out_data=0, out_count=0, out_partial=0, idle counter=0. Reset mid-beat discards the beat and the partial pack. FIFO contents are not this block's concern.
- States: FILL (accumulating), HOLD (beat presented, out_valid=1).
- `in_pop = in_valid && (state==FILL || (state==HOLD && out_ready))`. Never asserted when `in_valid`=0.
- FILL, pop: word written to lane `count`; count++.
  - If count reaches PACK → HOLD next cycle with out_count=PACK, out_partial=0.
- FILL, `flush_req`=1 and (count>0 or pop this cycle) → HOLD next cycle with the words held, including any word popped this cycle.
  - out_count=words, out_partial=(words<PACK).
  - Unfilled lanes are driven 0.
- FILL, `flush_req`=1, count=0, no pop: no-op. Empty beats are never emitted.
- Idle timer: increments each FILL cycle with count>0 and no pop. Clears on pop, on leaving FILL, and on reset.
  - When it reaches IDLE_TIMEOUT, behaves as a flush: HOLD next cycle.
  - IDLE_TIMEOUT=0: timer inactive.
- HOLD: out_data/out_count/out_partial stable while out_valid && !out_ready.
- HOLD && out_ready: beat accepted.
  - If pop in the same cycle, the popped word becomes lane 0 of the new pack (count=1, state FILL).
  - Otherwise count=0, state FILL.
  - Sustained throughput: one beat per PACK cycles with no bubble.
- `flush_req` is ignored in HOLD and re-evaluated in FILL.
- out_valid rises only from a registered state; there is no combinational path from `in_valid` to out_valid.
- Width rule: count is $clog2(PACK+1) bits and never exceeds PACK. Lane index uses count directly.

Decomposition:
- `fifo_pkg`: state enum type (FILL, HOLD), function `clog2p1(n)`, default widths shared with `fifo`.
- One natural sub-module: `fifo_idle_timer` (enable, clear, terminal-count pulse; parameter IDLE_TIMEOUT, collapses to constant 0 when IDLE_TIMEOUT=0).

Test Plan (DATA_WIDTH=8, PACK=4, IDLE_TIMEOUT=16):
- Full pack: in_valid=1, words 0x11,0x22,0x33,0x44, out_ready=1 → one beat, out_data=0x44332211, out_count=4, out_partial=0; in_pop high 4 consecutive cycles.
- Back-to-back with backpressure: 8 words streaming, out_ready=0 for 3 cycles on the first beat → first beat held stable, in_pop=0 during hold; second beat 0x88776655 follows with no word lost or duplicated.
- Explicit flush: push 0xA1,0xA2, then flush_req=1 one cycle → beat 0x0000A2A1, out_count=2, out_partial=1. flush_req with count=0 → no beat.
- Idle timeout: push 0x5A then in_valid=0 → out_valid rises after 16 idle cycles with out_count=1 and out_data=0x0000005A. IDLE_TIMEOUT=0 → no beat ever.
- Accept-and-pop same cycle: in HOLD with out_ready=1 and in_valid=1 carrying 0xEE → beat consumed, next beat's lane 0 = 0xEE, count=1.
- Reset mid-operation: rst_n=0 while in HOLD with count=3 → next cycle out_valid=0, out_data=0, busy=0, in_pop=0; the following 4 words form a clean beat.
